// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter, checker and load formatter in front of DMEM
module dmem_arbiter #(
    parameter int DMEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_type,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_type,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_we,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;
    localparam logic [32:0] MEM_LIMIT = 33'(DMEM_SIZE);

    logic        state;
    logic        last_grant;
    logic        cmd_we;
    logic        cmd_owner;
    logic        cmd_err;
    logic [2:0]  cmd_type;

    logic        any_req;
    logic        winner;
    logic        sel_we;
    logic [2:0]  sel_type;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_size;
    logic        sel_misalign;
    logic        sel_reserved;
    logic [32:0] sel_end;
    logic        sel_err;
    logic [31:0] load_fmt;
    logic [31:0] resp_data;

    // With both requesting, the port that did not win last time goes next.
    assign any_req = m0_req | m1_req;
    assign winner  = (m0_req & m1_req) ? ~last_grant : m1_req;
    assign m0_gnt  = (state == S_IDLE) & any_req & ~winner;
    assign m1_gnt  = (state == S_IDLE) & any_req & winner;

    assign sel_we    = winner ? m1_we    : m0_we;
    assign sel_type  = winner ? m1_type  : m0_type;
    assign sel_addr  = winner ? m1_addr  : m0_addr;
    assign sel_wdata = winner ? m1_wdata : m0_wdata;

    always_comb begin
        sel_size     = 3'd1;
        sel_misalign = 1'b0;
        sel_reserved = 1'b0;
        case (sel_type)
            3'b000, 3'b100: sel_size = 3'd1;
            3'b001, 3'b101: begin
                sel_size     = 3'd2;
                sel_misalign = sel_addr[0];
            end
            3'b010: begin
                sel_size     = 3'd4;
                sel_misalign = |sel_addr[1:0];
            end
            default: sel_reserved = 1'b1;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap past the range check.
    assign sel_end = {1'b0, sel_addr} + {30'd0, sel_size};
    assign sel_err = sel_reserved | sel_misalign | (sel_end > MEM_LIMIT);

    always_comb begin
        load_fmt = mem_rdata;
        case (cmd_type)
            3'b000:  load_fmt = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  load_fmt = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  load_fmt = {24'd0, mem_rdata[7:0]};
            3'b101:  load_fmt = {16'd0, mem_rdata[15:0]};
            default: load_fmt = mem_rdata;
        endcase
    end

    assign resp_data = (cmd_we | cmd_err) ? 32'd0 : load_fmt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cmd_we     <= 1'b0;
            cmd_owner  <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_type   <= 3'd0;
            mem_we     <= 1'b0;
            mem_type   <= 3'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            m0_rvalid  <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= 32'd0;
            m1_rvalid  <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= 32'd0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_we <= 1'b0;
                    if (any_req) begin
                        cmd_we     <= sel_we;
                        cmd_type   <= sel_type;
                        cmd_owner  <= winner;
                        cmd_err    <= sel_err;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_type   <= {1'b0, sel_type[1:0]};
                        mem_we     <= sel_we & ~sel_err;
                        last_grant <= winner;
                        state      <= S_BUSY;
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= S_IDLE;
                    if (cmd_owner) begin
                        m1_rvalid <= 1'b1;
                        m1_err    <= cmd_err;
                        m1_rdata  <= resp_data;
                    end else begin
                        m0_rvalid <= 1'b1;
                        m0_err    <= cmd_err;
                        m0_rdata  <= resp_data;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a byte-array reference memory
module tb_dmem_arbiter;
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   [2];
    logic        we    [2];
    logic [2:0]  typ   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    wire  [1:0]  gnt;
    wire  [1:0]  rvalid;
    wire  [1:0]  err;
    wire  [31:0] rdata0;
    wire  [31:0] rdata1;
    wire         mem_we;
    wire  [2:0]  mem_type;
    wire  [31:0] mem_addr;
    wire  [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [7:0]  dmem    [1024];
    logic [7:0]  ref_mem [1024];
    exp_t        q0[$];
    exp_t        q1[$];
    int          grant_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_wait;
    logic        last_gnt_rv;

    dmem_arbiter #(.DMEM_SIZE(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_type(typ[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata0), .m0_err(err[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_type(typ[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata1), .m1_err(err[1]),
        .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached DMEM: asynchronous little-endian read, write on the clock edge.
    always_comb begin
        mem_rdata = 32'd0;
        for (int i = 0; i < 4; i++)
            if (mem_addr + 32'(i) < 32'd1024)
                mem_rdata[8*i +: 8] = dmem[10'(mem_addr + 32'(i))];
    end

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < (mem_type == 3'd0 ? 1 : (mem_type == 3'd1 ? 2 : 4)); i++)
                if (mem_addr + 32'(i) < 32'd1024)
                    dmem[10'(mem_addr + 32'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: apply the access to ref_mem and return the response it must produce.
    function automatic exp_t model(input logic w, input logic [2:0] t, input logic [31:0] a,
                                   input logic [31:0] d);
        exp_t        e;
        int          sz;
        bit          bad;
        logic [31:0] raw;
        bad = 0;
        sz  = 1;
        case (t)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: begin sz = 2; bad = (a % 2) != 0; end
            3'd2:       begin sz = 4; bad = (a % 4) != 0; end
            default:    bad = 1;
        endcase
        if (longint'(a) + sz > 1024) bad = 1;
        e.err   = bad;
        e.rdata = 32'd0;
        e.cyc   = 0;
        if (!bad) begin
            if (w) begin
                for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            end else begin
                raw = 32'd0;
                for (int i = 0; i < sz; i++) raw[8*i +: 8] = ref_mem[int'(a) + i];
                case (t)
                    3'd0:    e.rdata = 32'($signed(raw[7:0]));
                    3'd1:    e.rdata = 32'($signed(raw[15:0]));
                    3'd4:    e.rdata = 32'(raw[7:0]);
                    3'd5:    e.rdata = 32'(raw[15:0]);
                    default: e.rdata = raw;
                endcase
            end
        end
        return e;
    endfunction

    task automatic access(input int p, input logic w, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d);
        exp_t e;
        int   n;
        @(negedge clk);
        req[p] = 1'b1; we[p] = w; typ[p] = t; addr[p] = a; wdata[p] = d;
        #1;
        n = 0;
        while (!gnt[p] && n < 64) begin
            @(negedge clk); #1;
            n++;
        end
        if (!gnt[p]) begin
            chk($sformatf("gnt_timeout_m%0d", p), 32'(gnt[p]), 32'd1);
            req[p] = 1'b0;
            return;
        end
        e = model(w, t, a, d);
        e.cyc = cyc + 2;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
        grant_log.push_back(p);
        last_wait   = n;
        last_gnt_rv = |rvalid;
        @(posedge clk); #1;
        req[p] = 1'b0;
        @(negedge clk); #1;
        chk("busy_mem_we", 32'(mem_we), 32'(w & ~e.err));
        chk("busy_mem_addr", mem_addr, a);
        if (t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
            chk("busy_mem_type", 32'(mem_type), 32'({1'b0, t[1:0]}));
    endtask

    task automatic rand_port(input int p);
        logic [31:0] a;
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(128, 159))
                                            : 32'($urandom_range(128, 1027));
            access(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (&rvalid) chk("rvalid_both", 32'(rvalid), 32'd1);
            for (int p = 0; p < 2; p++) begin
                if (rvalid[p]) begin
                    if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("unexpected_rvalid_m%0d", p), 32'd1, 32'd0);
                    end else begin
                        e = (p == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rvalid_cycle_m%0d", p), 32'(cyc), 32'(e.cyc));
                        chk($sformatf("err_m%0d", p), 32'(err[p]), 32'(e.err));
                        chk($sformatf("rdata_m%0d", p), p == 0 ? rdata0 : rdata1, e.rdata);
                    end
                end else if (err[p]) begin
                    chk($sformatf("err_without_rvalid_m%0d", p), 32'(err[p]), 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) begin dmem[i] = 8'd0; ref_mem[i] = 8'd0; end
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; typ[p] = 3'd0; addr[p] = 32'd0; wdata[p] = 32'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_type", 32'(mem_type), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rvalid_err", {28'd0, rvalid, err}, 32'd0);
        chk("rst_rdata", rdata0 | rdata1, 32'd0);
        rst_n = 1'b1;

        access(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        chk("first_gnt_wait", 32'(last_wait), 32'd0);
        access(1, 1'b0, 3'd2, 32'h10, 32'd0);
        @(negedge clk); #1;
        chk("lw_after_sw", rdata1, 32'hDEADBEEF);

        access(0, 1'b0, 3'd0, 32'h13, 32'd0); @(negedge clk); #1; chk("lb_0x13", rdata0, 32'hFFFFFFDE);
        access(0, 1'b0, 3'd4, 32'h13, 32'd0); @(negedge clk); #1; chk("lbu_0x13", rdata0, 32'h000000DE);
        access(0, 1'b0, 3'd1, 32'h10, 32'd0); @(negedge clk); #1; chk("lh_0x10", rdata0, 32'hFFFFBEEF);
        access(0, 1'b0, 3'd5, 32'h12, 32'd0); @(negedge clk); #1; chk("lhu_0x12", rdata0, 32'h0000DEAD);

        grant_log.delete();
        fork
            for (int k = 0; k < 4; k++) access(0, 1'b0, 3'd2, 32'h10, 32'd0);
            for (int k = 0; k < 4; k++) access(1, k[0], 3'd2, 32'h80 + 32'(4 * k), $urandom);
        join
        for (int i = 1; i < grant_log.size(); i++)
            chk("arb_alternate", 32'(grant_log[i] == grant_log[i-1]), 32'd0);

        access(1, 1'b1, 3'd1, 32'h11, 32'h5555);
        access(0, 1'b1, 3'd2, 32'h12, 32'h11111111);
        access(0, 1'b1, 3'd2, 32'h3FE, 32'h22222222);
        access(1, 1'b1, 3'd3, 32'h10, 32'h33333333);
        access(0, 1'b0, 3'd2, 32'h10, 32'd0);
        @(negedge clk); #1;
        chk("lw_after_errors", rdata0, 32'hDEADBEEF);

        access(0, 1'b1, 3'd0, 32'h20, 32'hAB);
        access(0, 1'b0, 3'd4, 32'h20, 32'd0);
        chk("b2b_gnt_with_rvalid", 32'(last_gnt_rv), 32'd1);
        @(negedge clk); #1;
        chk("b2b_lbu", rdata0, 32'h000000AB);

        fork
            rand_port(0);
            rand_port(1);
        join
        repeat (3) @(negedge clk);

        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; typ[1] = 3'd2; addr[1] = 32'h40; wdata[1] = 32'h12345678;
        #1;
        n = 0;
        while (!gnt[1] && n < 64) begin @(negedge clk); #1; n++; end
        chk("rst_case_gnt", 32'(gnt[1]), 32'd1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk); #1;
        chk("rst_case_busy_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_case_we_drop", 32'(mem_we), 32'd0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_case_no_rvalid", 32'(rvalid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_case_no_rvalid_after", 32'(rvalid), 32'd0);
        grant_log.delete();
        fork
            access(0, 1'b0, 3'd2, 32'h40, 32'd0);
            access(1, 1'b0, 3'd2, 32'h10, 32'd0);
        join
        chk("rst_case_first_grant_m0", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_case_lw_0x40", rdata0, 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
